// File: rtl/pe_link_arbiter.sv
// Packet-atomic round-robin arbiter sharing one registered outbound tile link among NUM_REQ
// requesters. Optional stall watchdog enabled by defining PE_LINK_ARB_WDOG_EN.
module pe_link_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 164,
  parameter int unsigned WDOG_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          wdog_err
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_LIMIT < 1) begin : g_bad_param
    $error("pe_link_arbiter: NUM_REQ must be 2..8 and WDOG_LIMIT at least 1");
  end

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e                  state_q, state_d;
  logic [IdW-1:0]          grant_q, grant_d;
  logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]          next_ptr;
  logic [IdW-1:0]          cand;
  logic [IdW-1:0]          win_idx;
  logic                    win_found;
  logic                    g_valid;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    out_free;
  logic                    xfer;
  logic                    wdog_hit;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_last_q;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Constant-index mux avoids wide variable part-selects into req_data.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign next_ptr = IdW'((32'(grant_q) + 1) % NUM_REQ);
  assign out_free = !out_valid_q || out_ready;
  assign xfer     = ap_start && (state_q == StPkt) && out_free && g_valid;

`ifdef PE_LINK_ARB_WDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_LIMIT + 1);

  logic [WdW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           wdog_err_q;

  // Counts cycles the granted requester leaves the link idle while enabled.
  assign wdog_hit = (state_q == StPkt) && ap_start && !g_valid &&
                    (wdog_cnt_q == WdW'(WDOG_LIMIT - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if ((state_q != StPkt) || xfer || wdog_hit) begin
      wdog_cnt_d = '0;
    end else if (ap_start && !g_valid) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_hit;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (ap_start && win_found) begin
          state_d = StPkt;
          grant_d = win_idx;
        end
      end
      StPkt: begin
        if ((xfer && g_last) || wdog_hit) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy      = (state_q == StPkt);
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = ap_start && (state_q == StPkt) && (grant_q == IdW'(i)) && out_free;
    end
  end

  // Output link register; drains on out_ready even while ap_start is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= g_data;
      out_last_q  <= g_last;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_pe_link_arbiter.sv
// Directed bench for pe_link_arbiter; the watchdog scenario runs only when
// PE_LINK_ARB_WDOG_EN is defined.
module tb_pe_link_arbiter;

  localparam int NR = 4;
  localparam int DW = 164;

  logic             clk = 1'b0;
  logic             reset;
  logic             ap_start;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             out_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             wdog_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_link_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .WDOG_LIMIT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ap_start (ap_start),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .grant_id (grant_id),
    .busy     (busy),
    .wdog_err (wdog_err)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input int r, input int k);
    return {8'(r), {37{4'h5}}, 8'(k)};
  endfunction

  task automatic drive(input int r, input logic v, input logic l, input int k);
    req_valid[r]           = v;
    req_last[r]            = l;
    req_data[r*DW +: DW]   = flit(r, k);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  int            cnt[NR];
  int            order[5] = '{0, 1, 2, 3, 0};
  logic [NR-1:0] xm;

  initial begin
    reset     = 1'b1;
    ap_start  = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    cyc;
    cyc;
    settle;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_data", 256'(out_data), 256'(0));
    check("rst_out_last", 256'(out_last), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_grant", 256'(grant_id), 256'(0));
    check("rst_ready", 256'(req_ready), 256'(0));
    check("rst_wdog", 256'(wdog_err), 256'(0));
    reset    = 1'b0;
    ap_start = 1'b1;

    // Single requester 1, three-flit packet.
    drive(1, 1'b1, 1'b0, 1);
    settle;
    check("t1_idle_ready", 256'(req_ready), 256'(0));
    cyc; settle;
    check("t1_grant", 256'(grant_id), 256'(1));
    check("t1_busy", 256'(busy), 256'(1));
    check("t1_ready", 256'(req_ready), 256'(4'b0010));
    check("t1_no_out", 256'(out_valid), 256'(0));
    cyc; drive(1, 1'b1, 1'b0, 2); settle;
    check("t1_a1_valid", 256'(out_valid), 256'(1));
    check("t1_a1_data", 256'(out_data), 256'(flit(1, 1)));
    check("t1_a1_last", 256'(out_last), 256'(0));
    cyc; drive(1, 1'b1, 1'b1, 3); settle;
    check("t1_a2_data", 256'(out_data), 256'(flit(1, 2)));
    check("t1_a2_last", 256'(out_last), 256'(0));
    cyc; drive(1, 1'b0, 1'b0, 0); settle;
    check("t1_a3_data", 256'(out_data), 256'(flit(1, 3)));
    check("t1_a3_last", 256'(out_last), 256'(1));
    check("t1_busy_fall", 256'(busy), 256'(0));
    cyc; settle;
    check("t1_drained", 256'(out_valid), 256'(0));
    // rr_ptr should now be 2: with 0, 2 and 3 requesting, 2 wins.
    drive(0, 1'b1, 1'b1, 9);
    drive(2, 1'b1, 1'b1, 9);
    drive(3, 1'b1, 1'b1, 9);
    cyc; settle;
    check("t1_rr_grant", 256'(grant_id), 256'(2));
    cyc; req_valid = '0; settle;
    check("t1_rr_data", 256'(out_data), 256'(flit(2, 9)));
    check("t1_rr_idle", 256'(busy), 256'(0));

    // Reset pulse, then all four requesters continuously valid with two-flit packets.
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    settle;
    check("t2_rst_busy", 256'(busy), 256'(0));
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < NR; i++) drive(i, 1'b1, cnt[i] == 1, cnt[i]);
      settle;
      check($sformatf("t2_busy_c%0d", c), 256'(busy), 256'(c % 3 != 0));
      if (c % 3 != 0) check($sformatf("t2_grant_c%0d", c), 256'(grant_id), 256'(order[c/3]));
      if (c % 3 == 2) begin
        check($sformatf("t2_f0_c%0d", c), 256'(out_data), 256'(flit(order[c/3], 0)));
        check($sformatf("t2_l0_c%0d", c), 256'(out_last), 256'(0));
      end
      if (c % 3 == 0 && c > 0) begin
        check($sformatf("t2_f1_c%0d", c), 256'(out_data), 256'(flit(order[c/3-1], 1)));
        check($sformatf("t2_l1_c%0d", c), 256'(out_last), 256'(1));
      end
      xm = req_valid & req_ready;
      cyc;
      for (int i = 0; i < NR; i++) if (xm[i]) cnt[i] = 1 - cnt[i];
    end

    // Backpressure: out_ready low for five cycles while flit 2 sits in the output register.
    req_valid = '0;
    drive(3, 1'b1, 1'b0, 0);
    settle;
    cyc; settle;
    check("t3_grant", 256'(grant_id), 256'(3));
    cyc; drive(3, 1'b1, 1'b0, 1); settle;
    check("t3_f0", 256'(out_data), 256'(flit(3, 0)));
    cyc; out_ready = 1'b0; drive(3, 1'b1, 1'b0, 2); settle;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin
        cyc; settle;
      end
      check($sformatf("t3_hold_valid_%0d", s), 256'(out_valid), 256'(1));
      check($sformatf("t3_hold_data_%0d", s), 256'(out_data), 256'(flit(3, 1)));
      check($sformatf("t3_hold_ready_%0d", s), 256'(req_ready), 256'(0));
    end
    cyc; out_ready = 1'b1; settle;
    check("t3_release_data", 256'(out_data), 256'(flit(3, 1)));
    check("t3_release_ready", 256'(req_ready), 256'(4'b1000));
    cyc; drive(3, 1'b1, 1'b1, 3); settle;
    check("t3_f2", 256'(out_data), 256'(flit(3, 2)));
    check("t3_f2_last", 256'(out_last), 256'(0));
    cyc; req_valid = '0; settle;
    check("t3_f3", 256'(out_data), 256'(flit(3, 3)));
    check("t3_f3_last", 256'(out_last), 256'(1));
    check("t3_idle", 256'(busy), 256'(0));
    cyc; settle;
    check("t3_drained", 256'(out_valid), 256'(0));

    // ap_start low: no grant from IDLE, then a three-cycle pause after flit 1.
    ap_start = 1'b0;
    drive(2, 1'b1, 1'b0, 0);
    settle;
    cyc; settle;
    check("t4_no_grant", 256'(busy), 256'(0));
    ap_start = 1'b1;
    cyc; settle;
    check("t4_grant", 256'(grant_id), 256'(2));
    cyc; ap_start = 1'b0; drive(2, 1'b1, 1'b0, 1); settle;
    check("t4_g0", 256'(out_data), 256'(flit(2, 0)));
    check("t4_g0_valid", 256'(out_valid), 256'(1));
    check("t4_off_ready0", 256'(req_ready), 256'(0));
    for (int s = 1; s < 3; s++) begin
      cyc; settle;
      check($sformatf("t4_off_drain_%0d", s), 256'(out_valid), 256'(0));
      check($sformatf("t4_off_busy_%0d", s), 256'(busy), 256'(1));
      check($sformatf("t4_off_grant_%0d", s), 256'(grant_id), 256'(2));
      check($sformatf("t4_off_ready_%0d", s), 256'(req_ready), 256'(0));
    end
    cyc; ap_start = 1'b1; settle;
    check("t4_resume_ready", 256'(req_ready), 256'(4'b0100));
    cyc; drive(2, 1'b1, 1'b0, 2); settle;
    check("t4_g1", 256'(out_data), 256'(flit(2, 1)));
    cyc; drive(2, 1'b1, 1'b1, 3); settle;
    check("t4_g2", 256'(out_data), 256'(flit(2, 2)));
    cyc; req_valid = '0; settle;
    check("t4_g3", 256'(out_data), 256'(flit(2, 3)));
    check("t4_g3_last", 256'(out_last), 256'(1));
    check("t4_idle", 256'(busy), 256'(0));

    // Reset mid-packet, then rr_ptr must be 0 again: with 2 and 3 requesting, 2 wins.
    drive(1, 1'b1, 1'b0, 0);
    settle;
    cyc; settle;
    check("t5_grant1", 256'(grant_id), 256'(1));
    cyc; drive(1, 1'b1, 1'b0, 1); reset = 1'b1; settle;
    check("t5_h0", 256'(out_data), 256'(flit(1, 0)));
    cyc; reset = 1'b0; req_valid = '0; settle;
    check("t5_rst_valid", 256'(out_valid), 256'(0));
    check("t5_rst_busy", 256'(busy), 256'(0));
    check("t5_rst_grant", 256'(grant_id), 256'(0));
    check("t5_rst_ready", 256'(req_ready), 256'(0));
    drive(2, 1'b1, 1'b0, 0);
    drive(3, 1'b1, 1'b1, 7);
    settle;
    cyc; settle;
    check("t5_grant2", 256'(grant_id), 256'(2));
    cyc; drive(2, 1'b1, 1'b1, 1); settle;
    check("t5_k0", 256'(out_data), 256'(flit(2, 0)));
    cyc; req_valid[2] = 1'b0; settle;
    check("t5_k1", 256'(out_data), 256'(flit(2, 1)));
    check("t5_k1_last", 256'(out_last), 256'(1));
    check("t5_idle", 256'(busy), 256'(0));
    cyc; settle;
    check("t5_grant3", 256'(grant_id), 256'(3));
    cyc; req_valid = '0; settle;
    check("t5_single", 256'(out_data), 256'(flit(3, 7)));
    check("t5_single_last", 256'(out_last), 256'(1));
    check("t5_single_idle", 256'(busy), 256'(0));

`ifdef PE_LINK_ARB_WDOG_EN
    // Requester 1 stalls after flit 1; watchdog releases after 8 stall cycles, 2 is next.
    drive(1, 1'b1, 1'b0, 0);
    drive(2, 1'b1, 1'b1, 5);
    settle;
    cyc; settle;
    check("t6_grant1", 256'(grant_id), 256'(1));
    cyc; req_valid[1] = 1'b0; settle;
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("t6_stall_err_%0d", n), 256'(wdog_err), 256'(0));
      check($sformatf("t6_stall_busy_%0d", n), 256'(busy), 256'(1));
      cyc; settle;
    end
    check("t6_err_pulse", 256'(wdog_err), 256'(1));
    check("t6_released", 256'(busy), 256'(0));
    cyc; settle;
    check("t6_err_clear", 256'(wdog_err), 256'(0));
    check("t6_grant2", 256'(grant_id), 256'(2));
    check("t6_busy2", 256'(busy), 256'(1));
    cyc; req_valid = '0; settle;
    check("t6_data2", 256'(out_data), 256'(flit(2, 5)));
`else
    check("t6_wdog_tied", 256'(wdog_err), 256'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
